// File: rtl/bcd_seq_ctrl.sv
// Digit-serial BCD adder sequencer: walks NDIG digit pairs through an external
// single-digit BCD adder, one digit per cycle, and assembles the registered sum.
module bcd_seq_ctrl #(
   parameter int unsigned NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [4*NDIG-1:0] op_a_i,
   input  logic [4*NDIG-1:0] op_b_i,
   input  logic              cin_i,
   output logic [3:0]        dig_a_o,
   output logic [3:0]        dig_b_o,
   output logic              dig_cin_o,
   input  logic [3:0]        dig_sum_i,
   input  logic              dig_carry_i,
   output logic [4*NDIG-1:0] result_o,
   output logic              cout_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // One spare index bit so the index can reach NDIG without wrapping.
   localparam int unsigned IdxW = $clog2(NDIG + 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e            state_q, state_d;
   logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
   logic [4*NDIG-1:0] result_q, result_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              err_q, err_d;
   logic              op_bad;
   logic [3:0]        cur_a, cur_b;

   always_comb begin
      op_bad = 1'b0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (op_a_i[4*i +: 4] > 4'd9 || op_b_i[4*i +: 4] > 4'd9) op_bad = 1'b1;
      end
   end

   always_comb begin
      cur_a = 4'd0;
      cur_b = 4'd0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (idx_q == IdxW'(i)) begin
            cur_a = a_q[4*i +: 4];
            cur_b = b_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      err_d     = err_q;
      dig_a_o   = 4'd0;
      dig_b_o   = 4'd0;
      dig_cin_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               a_d      = op_a_i;
               b_d      = op_b_i;
               carry_d  = cin_i;
               idx_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               err_d    = op_bad;
               state_d  = op_bad ? StDone : StAdd;
            end
         end
         StAdd: begin
            dig_a_o   = cur_a;
            dig_b_o   = cur_b;
            dig_cin_o = carry_q;
            // Adder output is stored unchecked, even if it is not a valid digit.
            for (int i = 0; i < int'(NDIG); i++) begin
               if (idx_q == IdxW'(i)) result_d[4*i +: 4] = dig_sum_i;
            end
            carry_d = dig_carry_i;
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == IdxW'(NDIG - 1)) begin
               cout_d  = dig_carry_i;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         err_q    <= err_d;
      end
   end

   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign err_o    = err_q;
   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Randomized bench for bcd_seq_ctrl: a behavioural adder drives the digit port and
// a decimal-arithmetic model predicts sum, carry, error flag and timing.
module tb_bcd_seq_ctrl;

   localparam int NDIG = 4;

   logic        clk, rst_n, start, cin;
   logic [15:0] op_a, op_b, result;
   logic [3:0]  dig_a, dig_b, dig_sum;
   logic        dig_cin, dig_carry, cout, busy, done, err;
   logic [4:0]  adder_s;

   int checks = 0;
   int errors = 0;

   bcd_seq_ctrl #(.NDIG(NDIG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .cin_i      (cin),
      .dig_a_o    (dig_a),
      .dig_b_o    (dig_b),
      .dig_cin_o  (dig_cin),
      .dig_sum_i  (dig_sum),
      .dig_carry_i(dig_carry),
      .result_o   (result),
      .cout_o     (cout),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   // External single-digit BCD adder.
   assign adder_s   = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
   assign dig_carry = (adder_s > 5'd9);
   assign dig_sum   = dig_carry ? 4'(adder_s - 5'd10) : adder_s[3:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                                   output logic [15:0] r, output logic co, output logic e);
      int va, vb, s, lim;
      e = 1'b0; va = 0; vb = 0; lim = 1; r = '0; co = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e = 1'b1;
         va = va * 10 + int'(a[i*4 +: 4]);
         vb = vb * 10 + int'(b[i*4 +: 4]);
         lim = lim * 10;
      end
      if (!e) begin
         s  = va + vb + int'(c);
         co = (s >= lim);
         s  = s % lim;
         for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
         end
      end
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int i = 0; i < NDIG; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // One transaction; restart re-asserts start mid-ADD with different operands.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input bit restart);
      logic [15:0] er, seq_a, seq_b;
      logic        ec, ee;
      int          lat, ndone, nadd;
      bit          seen;
      ref_add(a, b, c, er, ec, ee);
      @(negedge clk);
      op_a = a; op_b = b; cin = c; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; ndone = 0; nadd = 0; seen = 0; seq_a = '0; seq_b = '0;
      for (int k = 1; k <= NDIG + 3; k++) begin
         @(negedge clk);
         if (seen && k == lat + 1) begin
            check_eq("start_in_done_ignored", 32'(busy), 32'(0));
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            if (!seen) begin
               seen = 1;
               lat  = k;
               check_eq("result", 32'(result), 32'(er));
               check_eq("cout", 32'(cout), 32'(ec));
               check_eq("err", 32'(err), 32'(ee));
               check_eq("dig_idle_zero", 32'({dig_a, dig_b, dig_cin}), 32'(0));
               start = 1'b1;
            end
         end else if (busy) begin
            if (nadd < NDIG) begin
               seq_a[nadd*4 +: 4] = dig_a;
               seq_b[nadd*4 +: 4] = dig_b;
               if (nadd == 0) check_eq("first_dig_cin", 32'(dig_cin), 32'(c));
            end
            nadd++;
         end
         if (restart && k == 2) begin
            op_a = rand_bcd(); op_b = rand_bcd(); cin = ~c; start = 1'b1;
         end
         if (restart && k == 3) start = 1'b0;
      end
      start = 1'b0;
      check_eq("latency", 32'(lat), ee ? 32'(1) : 32'(NDIG + 1));
      check_eq("done_pulses", 32'(ndone), 32'(1));
      check_eq("add_cycles", 32'(nadd), ee ? 32'(0) : 32'(NDIG));
      if (!ee) begin
         check_eq("dig_a_seq", 32'(seq_a), 32'(a));
         check_eq("dig_b_seq", 32'(seq_b), 32'(b));
      end
      @(negedge clk);
      check_eq("hold_result", 32'({result, cout, err}), 32'({er, ec, ee}));
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("reset_outs", 32'({result, cout, busy, done, err}), 32'(0));
      check_eq("reset_digs", 32'({dig_a, dig_b, dig_cin}), 32'(0));
      rst_n = 1'b1;

      run_op(16'h0999, 16'h0001, 1'b0, 0);
      run_op(16'h9999, 16'h0001, 1'b0, 0);
      run_op(16'h1234, 16'h5678, 1'b1, 0);
      run_op(16'h00A0, 16'h0001, 1'b0, 0);
      run_op(16'h4321, 16'h1111, 1'b0, 1);

      // Reset on the second ADD cycle aborts without a done pulse.
      @(negedge clk);
      op_a = 16'h5555; op_b = 16'h4444; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(busy), 32'(0));
      check_eq("abort_result", 32'(result), 32'(0));
      check_eq("abort_done", 32'(done), 32'(0));
      @(negedge clk);
      check_eq("abort_still_idle", 32'({busy, done}), 32'(0));
      rst_n = 1'b1;
      run_op(16'h0456, 16'h0789, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, NDIG - 1) +: 4] =
            4'($urandom_range(10, 15));
         run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) &&
                (ra[3:0] <= 4'd9 && ra[7:4] <= 4'd9 && ra[11:8] <= 4'd9 && ra[15:12] <= 4'd9));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
